// File: rtl/oirv_ui_pkg.sv
// Shared types and helpers for the UI input conditioning blocks.
// Debouncer FSM state encoding plus a millisecond-to-clock-tick conversion.
package oirv_ui_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'b00,
    PRESS_CHK   = 2'b01,
    PRESSED     = 2'b10,
    RELEASE_CHK = 2'b11
  } db_state_t;

  // Whole kHz first so large clock rates stay inside 32 bits.
  function automatic logic [31:0] ms_to_ticks(input int unsigned clk_hz,
                                              input int unsigned ms);
    int unsigned ticks;
    ticks = (clk_hz / 32'd1000) * ms;
    return ticks;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input pin.
// RESET_VAL lets each pin come out of reset at its idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Button conditioner: synchronise, debounce with a stable-time counter, and
// emit a clean level plus registered press / release / long-press strobes.
module button_debouncer
  import oirv_ui_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 27000000,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 1000,
  parameter logic        ACTIVE_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam logic [31:0] DB_TICKS   = ms_to_ticks(CLK_HZ, DEBOUNCE_MS);
  localparam logic [31:0] LONG_TICKS = ms_to_ticks(CLK_HZ, LONG_PRESS_MS);
  localparam bit          LONG_EN    = (LONG_PRESS_MS != 0);

  generate
    if (DB_TICKS < 32'd1) begin : g_bad_debounce
      $error("button_debouncer: debounce window must be at least one clock");
    end
  endgenerate

  logic sync_q;
  logic act;

  sync_2ff #(
    .RESET_VAL(~ACTIVE_LEVEL)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_in),
    .q  (sync_q)
  );

  assign act = (sync_q == ACTIVE_LEVEL);

  db_state_t   state, state_n;
  logic [31:0] db_cnt, db_cnt_n;
  logic [31:0] long_cnt, long_cnt_n;
  logic        long_fired, long_fired_n;
  logic        level_n, press_n, release_n, long_n;
  logic        long_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RELEASED;
      db_cnt      <= '0;
      long_cnt    <= '0;
      long_fired  <= 1'b0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
    end else begin
      state       <= state_n;
      db_cnt      <= db_cnt_n;
      long_cnt    <= long_cnt_n;
      long_fired  <= long_fired_n;
      btn_level   <= level_n;
      btn_press   <= press_n;
      btn_release <= release_n;
      btn_long    <= long_n;
    end
  end

  always_comb begin
    state_n      = state;
    db_cnt_n     = db_cnt;
    long_cnt_n   = long_cnt;
    long_fired_n = long_fired;
    level_n      = btn_level;
    press_n      = 1'b0;
    release_n    = 1'b0;
    long_n       = 1'b0;
    long_run     = 1'b0;

    case (state)
      RELEASED: begin
        db_cnt_n = '0;
        if (act) state_n = PRESS_CHK;
      end

      PRESS_CHK: begin
        if (!act) begin
          state_n  = RELEASED;
          db_cnt_n = '0;
        end else if (db_cnt == DB_TICKS - 32'd1) begin
          state_n      = PRESSED;
          db_cnt_n     = '0;
          level_n      = 1'b1;
          press_n      = 1'b1;
          long_cnt_n   = '0;
          long_fired_n = 1'b0;
        end else begin
          db_cnt_n = db_cnt + 32'd1;
        end
      end

      PRESSED: begin
        db_cnt_n = '0;
        long_run = 1'b1;
        if (!act) state_n = RELEASE_CHK;
      end

      RELEASE_CHK: begin
        long_run = 1'b1;
        if (act) begin
          state_n  = PRESSED;
          db_cnt_n = '0;
        end else if (db_cnt == DB_TICKS - 32'd1) begin
          state_n   = RELEASED;
          db_cnt_n  = '0;
          level_n   = 1'b0;
          release_n = 1'b1;
        end else begin
          db_cnt_n = db_cnt + 32'd1;
        end
      end

      default: state_n = RELEASED;
    endcase

    // Hold time keeps counting through release bounce; it stops once fired.
    if (long_run && LONG_EN && !long_fired) begin
      if (long_cnt == LONG_TICKS - 32'd1) begin
        long_n       = 1'b1;
        long_fired_n = 1'b1;
      end else begin
        long_cnt_n = long_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench: DB_TICKS=4, LONG_TICKS=20, active-low pin, plus a second
// instance with long press disabled sharing the same pin and reset.
module tb_button_debouncer;

  logic clk;
  logic rst;
  logic btn_in;
  logic btn_level, btn_press, btn_release, btn_long;
  logic nl_level, nl_press, nl_release, nl_long;

  button_debouncer #(
    .CLK_HZ(4000), .DEBOUNCE_MS(1), .LONG_PRESS_MS(5), .ACTIVE_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_long(btn_long)
  );

  button_debouncer #(
    .CLK_HZ(4000), .DEBOUNCE_MS(1), .LONG_PRESS_MS(0), .ACTIVE_LEVEL(1'b0)
  ) dut_nl (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(nl_level), .btn_press(nl_press),
    .btn_release(nl_release), .btn_long(nl_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int press_cnt = 0, release_cnt = 0, long_cnt = 0;
  int nl_press_cnt = 0, nl_release_cnt = 0, nl_long_cnt = 0;
  int last_press_cyc = -1, last_release_cyc = -1, last_long_cyc = -1;
  int overlap_cnt = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) cyc++;

  // Strobes are tallied mid-cycle, tagged with the index of the edge that set them.
  always @(negedge clk) begin
    if (btn_press) begin press_cnt++; last_press_cyc = cyc; end
    if (btn_release) begin release_cnt++; last_release_cyc = cyc; end
    if (btn_long) begin long_cnt++; last_long_cyc = cyc; end
    if (nl_press) nl_press_cnt++;
    if (nl_release) nl_release_cnt++;
    if (nl_long) nl_long_cnt++;
    if (btn_press && btn_release) overlap_cnt++;
  end

  typedef struct {
    logic pin;
    int   cycles;
    int   exp_press;
    int   exp_release;
    int   exp_long;
    logic exp_level;
  } vec_t;

  vec_t vecs [15];

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic pin, input int n);
    btn_in = pin;
    repeat (n) @(negedge clk);
    #1;
  endtask

  int p0, r0, l0, np0, nr0, nl0;
  int n0, r_start, m0;

  task automatic snap();
    p0 = press_cnt; r0 = release_cnt; l0 = long_cnt;
    np0 = nl_press_cnt; nr0 = nl_release_cnt; nl0 = nl_long_cnt;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 10,  0, 0, 0, 1'b0};
    vecs[1]  = '{1'b0, 3,   0, 0, 0, 1'b0};
    vecs[2]  = '{1'b1, 1,   0, 0, 0, 1'b0};
    vecs[3]  = '{1'b0, 2,   0, 0, 0, 1'b0};
    vecs[4]  = '{1'b1, 10,  0, 0, 0, 1'b0};
    vecs[5]  = '{1'b0, 10,  1, 0, 0, 1'b1};
    vecs[6]  = '{1'b1, 12,  0, 1, 0, 1'b0};
    vecs[7]  = '{1'b0, 8,   1, 0, 0, 1'b1};
    vecs[8]  = '{1'b1, 20,  0, 1, 0, 1'b0};
    vecs[9]  = '{1'b0, 20,  1, 0, 0, 1'b1};
    vecs[10] = '{1'b1, 2,   0, 0, 0, 1'b1};
    vecs[11] = '{1'b0, 1,   0, 0, 0, 1'b1};
    vecs[12] = '{1'b1, 10,  0, 1, 1, 1'b0};
    vecs[13] = '{1'b0, 100, 1, 0, 1, 1'b1};
    vecs[14] = '{1'b1, 12,  0, 1, 0, 1'b0};

    rst = 1'b1;
    btn_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_output("reset_level", int'(btn_level), 0);
    check_output("reset_press", int'(btn_press), 0);
    check_output("reset_release", int'(btn_release), 0);
    check_output("reset_long", int'(btn_long), 0);
    check_output("reset_nl_level", int'(nl_level), 0);
    rst = 1'b0;
    apply_stimulus(1'b1, 5);

    for (int i = 0; i < 15; i++) begin
      snap();
      apply_stimulus(vecs[i].pin, vecs[i].cycles);
      check_output($sformatf("row%0d_press", i), press_cnt - p0, vecs[i].exp_press);
      check_output($sformatf("row%0d_release", i), release_cnt - r0, vecs[i].exp_release);
      check_output($sformatf("row%0d_long", i), long_cnt - l0, vecs[i].exp_long);
      check_output($sformatf("row%0d_level", i), int'(btn_level), int'(vecs[i].exp_level));
      check_output($sformatf("row%0d_nl_press", i), nl_press_cnt - np0, vecs[i].exp_press);
      check_output($sformatf("row%0d_nl_release", i), nl_release_cnt - nr0, vecs[i].exp_release);
      check_output($sformatf("row%0d_nl_long", i), nl_long_cnt - nl0, 0);
      check_output($sformatf("row%0d_nl_level", i), int'(nl_level), int'(vecs[i].exp_level));
    end

    // Clean press: exact press and long-press edge positions.
    snap();
    n0 = cyc + 1;
    apply_stimulus(1'b0, 60);
    check_output("clean_press_cycle", last_press_cyc, n0 + 6);
    check_output("clean_long_cycle", last_long_cyc, n0 + 26);
    check_output("clean_press_count", press_cnt - p0, 1);
    check_output("clean_long_count", long_cnt - l0, 1);
    check_output("clean_nl_long_count", nl_long_cnt - nl0, 0);
    check_output("clean_level", int'(btn_level), 1);

    // Release bounce: high 2, low 1, high 10; release after last stable window.
    snap();
    r_start = cyc + 1;
    apply_stimulus(1'b1, 2);
    apply_stimulus(1'b0, 1);
    apply_stimulus(1'b1, 10);
    check_output("relbounce_release_cycle", last_release_cyc, r_start + 9);
    check_output("relbounce_release_count", release_cnt - r0, 1);
    check_output("relbounce_press_count", press_cnt - p0, 0);
    check_output("relbounce_level", int'(btn_level), 0);
    apply_stimulus(1'b1, 5);

    // Reset mid-hold with the long counter at 10, then a fresh press.
    n0 = cyc + 1;
    apply_stimulus(1'b0, 17);
    check_output("midhold_level_before", int'(btn_level), 1);
    snap();
    rst = 1'b1;
    #1;
    check_output("midhold_rst_level", int'(btn_level), 0);
    check_output("midhold_rst_press", int'(btn_press), 0);
    check_output("midhold_rst_release", int'(btn_release), 0);
    check_output("midhold_rst_long", int'(btn_long), 0);
    apply_stimulus(1'b0, 2);
    rst = 1'b0;
    m0 = cyc + 1;
    apply_stimulus(1'b0, 30);
    check_output("midhold_repress_cycle", last_press_cyc, m0 + 6);
    check_output("midhold_relong_cycle", last_long_cyc, m0 + 26);
    check_output("midhold_press_count", press_cnt - p0, 1);
    check_output("midhold_long_count", long_cnt - l0, 1);
    check_output("midhold_release_count", release_cnt - r0, 0);
    check_output("midhold_level_after", int'(btn_level), 1);
    apply_stimulus(1'b1, 12);
    check_output("final_level", int'(btn_level), 0);

    check_output("press_release_overlap", overlap_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
